// File: rtl/bht_tagged_param.sv
// Tagged branch history table: combinational lookup, read-modify-write training
// with saturating counters, and a one-entry-per-cycle invalidate-all sequencer.
module bht_tagged_param #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 16,
    parameter int TAG_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PC_W-1:0]  rd_pc,
    output logic             rd_hit,
    output logic             rd_taken,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             upd_en,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             dbg_state
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT  = CTR_WT - CTR_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Handshake: upd_en is a single-cycle strobe sampled at the rising edge; it is
    // taken only when enable=1 and no flush is running, otherwise it is dropped.
    // flush_req is likewise a strobe, honoured only while idle.

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_flush_idx;
    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_W-1:0]      r_tag [ENTRIES];
    logic [CTR_W-1:0]      r_ctr [ENTRIES];

    logic [IDX_W-1:0]      w_rd_idx;
    logic [TAG_W-1:0]      w_rd_tag;
    logic                  w_rd_hit;
    logic [CTR_W-1:0]      w_rd_ctr;
    logic [IDX_W-1:0]      w_upd_idx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_upd_hit;
    logic [CTR_W-1:0]      w_upd_ctr;
    logic                  w_upd_fire;
    logic                  w_flush_clr;
    logic                  w_busy;
    logic                  w_unused;

    assign w_rd_idx  = rd_pc[IDX_W-1:0];
    assign w_rd_tag  = rd_pc[IDX_W +: TAG_W];
    assign w_upd_idx = upd_pc[IDX_W-1:0];
    assign w_upd_tag = upd_pc[IDX_W +: TAG_W];
    assign w_unused  = ^{rd_pc, upd_pc};

    // Lookup sees registered contents only, so a same-cycle write is not bypassed.
    assign w_rd_hit = !w_busy && r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign w_rd_ctr = w_rd_hit ? r_ctr[w_rd_idx] : '0;
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    assign rd_hit   = w_rd_hit;
    assign rd_ctr   = w_rd_ctr;
    assign rd_taken = w_rd_ctr[CTR_W-1];

    // Weak-taken / weak-not-taken allocation collapses to upd_taken when CTR_W is 1.
    always_comb begin
        w_upd_ctr = r_ctr[w_upd_idx];
        if (!w_upd_hit) begin
            w_upd_ctr = upd_taken ? CTR_WT : CTR_WNT;
        end else if (upd_taken) begin
            if (r_ctr[w_upd_idx] != CTR_MAX) w_upd_ctr = r_ctr[w_upd_idx] + CTR_W'(1);
        end else begin
            if (r_ctr[w_upd_idx] != '0) w_upd_ctr = r_ctr[w_upd_idx] - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (flush_req) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_idx == IDX_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == ST_FLUSH);
        w_flush_clr = (r_state == ST_FLUSH);
        w_upd_fire  = upd_en && enable && (r_state == ST_IDLE);
    end

    assign flush_busy = w_busy;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_flush_idx <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_ctr[i] <= '0;
            end
        end else if (w_flush_clr) begin
            r_valid[r_flush_idx] <= 1'b0;
            r_flush_idx <= (r_flush_idx == IDX_LAST) ? '0 : r_flush_idx + IDX_W'(1);
        end else if (w_upd_fire) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_tag[w_upd_idx]   <= w_upd_tag;
            r_ctr[w_upd_idx]   <= w_upd_ctr;
        end
    end

endmodule
